// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, grant
// encodings and default FIFO geometry.
package uart_tx_arbiter_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_AW    = 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic GNT_CPU  = 1'b0;
  localparam logic GNT_ECHO = 1'b1;

endpackage

// File: rtl/sync_fifo8.sv
// Byte-wide synchronous FIFO with registered occupancy count; full and empty
// are decoded from the registered count only.
module sync_fifo8
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: the storage array has no reset; pointers and count alone decide
  // which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so wrap at DEPTH is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin merge of CPU and echo bytes into one transmit FIFO, drained by
// a start/busy handshake FSM in front of the UART TX core.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ready,
  input  logic          echo_valid,
  input  logic [7:0]    echo_data,
  output logic          echo_ready,
  input  logic          echo_en,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [AW:0]   fifo_count,
  output logic          cpu_drop,
  output logic          irq_idle
);

  tx_state_t  state;
  tx_state_t  state_next;
  logic       last_grant;
  logic       grant;
  logic       req_c;
  logic       req_e;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] push_data;
  logic [7:0] fifo_dout;

  assign req_c = cpu_we;
  assign req_e = echo_valid & echo_en;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    push     = 1'b0;
    grant    = GNT_CPU;
    cpu_drop = 1'b0;
    if (!reset) begin
      if (full) begin
        cpu_drop = cpu_we;
      end else if (req_c && req_e) begin
        push  = 1'b1;
        grant = (last_grant == GNT_CPU) ? GNT_ECHO : GNT_CPU;
      end else if (req_c) begin
        push  = 1'b1;
        grant = GNT_CPU;
      end else if (req_e) begin
        push  = 1'b1;
        grant = GNT_ECHO;
      end
    end
  end

  assign cpu_ready  = push & (grant == GNT_CPU);
  assign echo_ready = push & (grant == GNT_ECHO);
  assign push_data  = (grant == GNT_ECHO) ? echo_data : cpu_data;

  sync_fifo8 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= GNT_ECHO;
      tx_data    <= 8'h00;
      irq_idle   <= 1'b1;
    end else begin
      state <= state_next;
      if (push) last_grant <= grant;
      if (pop)  tx_data    <= fifo_dout;
      irq_idle <= empty && (state == S_IDLE);
    end
  end

  // Start and pop are suppressed while reset is held so a transfer cannot
  // leak out of a state that reset is about to discard.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!reset && !empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        tx_start   = !reset;
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: accepted bytes are queued as they are
// driven and compared when a behavioural TX core sees each start pulse.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_we;
  logic [7:0] cpu_data;
  logic       cpu_ready;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       echo_ready;
  logic       echo_en;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [3:0] fifo_count;
  logic       cpu_drop;
  logic       irq_idle;

  logic       hold_busy;
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .echo_en    (echo_en),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .cpu_drop   (cpu_drop),
    .irq_idle   (irq_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural TX core: busy rises the edge after a start pulse and stays up
  // for BUSY_LEN more cycles, or indefinitely while hold_busy is set.
  initial begin
    logic st;
    int   busy_cnt;
    tx_busy  = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      st = tx_start;
      if (reset) check("start_in_reset", tx_start, 0);
      if (st) begin
        if (exp_q.size() > 0) check("tx_order", tx_data, exp_q.pop_front());
        else                  check("tx_unexpected_start", tx_start, 0);
      end
      @(posedge clk);
      #1;
      if (reset) begin
        tx_busy  = 1'b0;
        busy_cnt = 0;
      end else if (hold_busy) begin
        tx_busy = 1'b1;
      end else if (st) begin
        tx_busy  = 1'b1;
        busy_cnt = BUSY_LEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic cpu_write(input logic [7:0] b);
    int n = 0;
    while (fifo_count == 4'd8 && n < 200) begin
      step();
      n++;
    end
    cpu_we   = 1'b1;
    cpu_data = b;
    @(negedge clk);
    check("cpu_ready", cpu_ready, 1);
    check("cpu_drop_quiet", cpu_drop, 0);
    exp_q.push_back(b);
    step();
    cpu_we = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int  n = 0;
    logic done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (fifo_count == 4'd0) && irq_idle && !tx_busy;
      n++;
    end
    check(tag, done, 1);
    step();
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int n = 0;
    @(negedge clk);
    while (tx_busy !== level && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_busy, level);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_cpu;
    logic [7:0] nc;
    int         n;

    reset = 1'b1; cpu_we = 1'b0; cpu_data = 8'h00; echo_valid = 1'b0;
    echo_data = 8'h00; echo_en = 1'b1; hold_busy = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_echo_ready", echo_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_cpu_drop", cpu_drop, 0);
    check("rst_irq_idle", irq_idle, 1);
    step();
    reset = 1'b0;
    step();

    // Single CPU byte and its latency
    cpu_we = 1'b1; cpu_data = 8'h41;
    @(negedge clk);
    check("single_ready", cpu_ready, 1);
    exp_q.push_back(8'h41);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    check("single_c1_start", tx_start, 0);
    check("single_c1_count", fifo_count, 1);
    check("single_c1_irq", irq_idle, 1);
    step();
    @(negedge clk);
    check("single_c2_start", tx_start, 1);
    check("single_c2_data", tx_data, 8'h41);
    check("single_c2_irq", irq_idle, 0);
    wait_busy(1'b1, "single_busy_rise");
    wait_busy(1'b0, "single_busy_fall");
    check("single_irq_at_fall", irq_idle, 0);
    @(negedge clk);
    check("single_irq_lag", irq_idle, 0);
    @(negedge clk);
    check("single_irq_up", irq_idle, 1);
    step();

    // Simultaneous requests alternate starting with CPU after reset
    do_reset();
    exp_cpu = 4'b0101;
    nc = 8'h00;
    echo_valid = 1'b1; echo_data = 8'h20; echo_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1;
      cpu_data = 8'h10 + nc;
      @(negedge clk);
      check("rr_cpu_ready", cpu_ready, exp_cpu[i]);
      check("rr_echo_ready", echo_ready, !exp_cpu[i]);
      if (exp_cpu[i]) begin
        exp_q.push_back(8'h10 + nc);
        nc++;
      end else begin
        exp_q.push_back(8'h20);
      end
      step();
    end
    cpu_we = 1'b0; echo_valid = 1'b0;
    wait_drain("rr_drain");

    // Full FIFO: drop, echo stall, then echo accepted after a pop
    hold_busy = 1'b1;
    step(); step();
    for (int i = 0; i < 8; i++) cpu_write(8'(i));
    check("full_count", fifo_count, 8);
    cpu_we = 1'b1; cpu_data = 8'h08;
    echo_valid = 1'b1; echo_data = 8'h66;
    @(negedge clk);
    check("full_cpu_drop", cpu_drop, 1);
    check("full_cpu_ready", cpu_ready, 0);
    check("full_echo_ready", echo_ready, 0);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    check("full_drop_once", cpu_drop, 0);
    check("full_echo_pending", echo_ready, 0);
    step();
    hold_busy = 1'b0;
    n = 0;
    @(negedge clk);
    while (!echo_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("full_echo_after_pop", echo_ready, 1);
    exp_q.push_back(8'h66);
    step();
    echo_valid = 1'b0;
    wait_drain("full_drain");

    // Same-cycle push and pop, then pointer wrap over further bytes
    hold_busy = 1'b1;
    step(); step();
    cpu_write(8'hA0); cpu_write(8'hA1); cpu_write(8'hA2);
    check("pp_count_before", fifo_count, 3);
    hold_busy = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    cpu_we = 1'b1; cpu_data = 8'hA3;
    #1;
    check("pp_cpu_ready", cpu_ready, 1);
    exp_q.push_back(8'hA3);
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    check("pp_count_same", fifo_count, 3);
    for (int i = 4; i < 13; i++) cpu_write(8'hA0 + 8'(i));
    wait_drain("pp_drain");

    // echo_en masks echo requests until raised
    echo_en = 1'b0; echo_valid = 1'b1; echo_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mask_echo_ready", echo_ready, 0);
      check("mask_count", fifo_count, 0);
      step();
    end
    echo_en = 1'b1;
    @(negedge clk);
    check("unmask_echo_ready", echo_ready, 1);
    exp_q.push_back(8'h55);
    step();
    echo_valid = 1'b0;
    wait_drain("mask_drain");

    // Reset while waiting for TX done with five bytes queued
    cpu_write(8'h30);
    n = 0;
    @(negedge clk);
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    hold_busy = 1'b1;
    step();
    for (int i = 1; i < 6; i++) cpu_write(8'h30 + 8'(i));
    check("rst_mid_count", fifo_count, 5);
    reset = 1'b1;
    hold_busy = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_start0", tx_start, 0);
    step();
    @(negedge clk);
    check("rst_mid_count0", fifo_count, 0);
    check("rst_mid_irq", irq_idle, 1);
    check("rst_mid_tx_data", tx_data, 8'h00);
    check("rst_mid_start1", tx_start, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_start", tx_start, 0);
    step();
    cpu_write(8'h77);
    wait_drain("rst_after_drain");

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources:
  - CPU stores arriving through the system bridge.
  - The hardware echo path fed by the UART receiver.
- Merges both sources into one 8-deep transmit FIFO using round-robin arbitration.
- Sequences the UART TX core with a start/busy handshake.
- Raises an interrupt when the transmit path drains to idle.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, minimum 2.
- AW, 3, log2(DEPTH); FIFO pointer width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cpu_we  input  1  CPU byte-write request (one-cycle strobe from bridge)
- cpu_data  input  8  CPU byte
- cpu_ready  output  1  CPU write accepted this cycle
- echo_valid  input  1  echo byte request (held until accepted)
- echo_data  input  8  echo byte
- echo_ready  output  1  echo byte accepted this cycle
- echo_en  input  1  config: 0 masks echo requests entirely
- tx_start  output  1  one-cycle start pulse to UART TX core
- tx_data  output  8  byte presented to TX core; stable from the start pulse until busy falls
- tx_busy  input  1  TX core busy
- fifo_count  output  AW+1  bytes currently queued
- cpu_drop  output  1  one-cycle pulse: CPU write rejected because the FIFO was full
- irq_idle  output  1  level: FIFO empty and FSM in IDLE

Behaviour:
- Reset values: cpu_ready=0, echo_ready=0, tx_start=0, tx_data=0, fifo_count=0, cpu_drop=0, irq_idle=1. FSM=IDLE; last_grant=ECHO, so the CPU wins the first tie.
- Full/empty:
  - full = (count==DEPTH); empty = (count==0).
  - Both are evaluated from registered count only; no same-cycle bypass.
- Arbitration (combinational, at most one push per cycle):
  - req_c = cpu_we; req_e = echo_valid & echo_en.
  - full: no grant. cpu_drop = cpu_we (combinational pulse). echo_valid stays pending.
  - One requester only: grant it.
  - Both requesting: grant the source not equal to last_grant.
  - last_grant updates on every grant.
  - cpu_ready / echo_ready = the respective grant.
- Push: granted byte written at wr_ptr; wr_ptr increments and wraps at DEPTH.
- Pop: rd_ptr increments and wraps at DEPTH.
- Count: push and pop in the same cycle leave count unchanged. Push while full cannot occur. Pop while empty cannot occur.
- TX FSM states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: if !empty and !tx_busy, then tx_data <= fifo[rd_ptr], pop, go to START.
  - START: tx_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE. No timeout; the TX core guarantees busy within 2 cycles.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
  - Minimum spacing between tx_start pulses is 4 cycles plus the busy duration.
- Latency: a byte pushed into an empty FIFO with the FSM in IDLE is popped on the next edge; tx_start asserts 2 cycles after the push edge.
- irq_idle = empty & (state==IDLE), registered (one cycle behind the condition).
- echo_en deassertion:
  - Takes effect the same cycle for new grants.
  - Echo bytes already queued still transmit.
- Reset mid-transmission:
  - FIFO contents are discarded; pointers and count are zeroed; FSM returns to IDLE.
  - tx_start is never emitted during or on the cycle after reset.
- tx_busy high at reset release: the FSM waits in IDLE until busy falls.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: S_IDLE=2'd0, S_START=2'd1, S_WAIT_BUSY=2'd2, S_WAIT_DONE=2'd3.
  - Grant encodings: GNT_CPU=1'b0, GNT_ECHO=1'b1.
  - DEPTH/AW defaults.
- One natural sub-module, sync_fifo8:
  - Holds the storage array, pointers, count, full and empty.
  - Ports: clk, reset, push, din, pop, dout, count, full, empty.
- The arbiter and TX FSM stay in the top level.

Test Plan:
- Single CPU byte: cpu_we with 0x41 into an empty FIFO -> cpu_ready=1 that cycle; tx_start 2 cycles later with tx_data=0x41; irq_idle=0 until tx_busy falls, then 1 one cycle after FSM returns to IDLE.
- Simultaneous requests: cpu_we(0x10) and echo_valid(0x20) held for 4 cycles, CPU issuing a new byte each cycle (0x10,0x11) -> grants CPU, ECHO, CPU, ECHO. FIFO order 0x10,0x20,0x11,0x20 (echo_valid held with 0x20). Transmitted in that order.
- Full FIFO: tx_busy held high, 8 CPU writes 0x00..0x07 -> fifo_count=8. 9th write gives cpu_drop=1 and cpu_ready=0. Pending echo_valid gets echo_ready=0 until a pop, then accepted. Drain order 0x00..0x07, then the echo byte.
- Push/pop same cycle: count=3, FSM in IDLE, tx_busy=0, cpu_we asserted -> count stays 3; rd and wr pointers wrap correctly across index 7->0 over 10 bytes.
- echo_en=0 with echo_valid=1 and byte 0x55 -> echo_ready never asserts and the FIFO is unchanged. Raise echo_en -> accepted next cycle.
- Reset asserted in WAIT_DONE with count=5 -> the next cycle shows count=0 and irq_idle=1; tx_start=0 throughout; a new byte after reset transmits normally.
